// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared core sizing constants and register-index helpers
// Exports: CORE_NREGS (architectural register count), CORE_XLEN (data width),
//          REG_AW (register-index width), reg_addr_t, wr_active(), addr_in_range().
package regfile_pkg;

  localparam int CORE_NREGS = 32;
  localparam int CORE_XLEN  = 32;
  localparam int REG_AW     = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // A write port only does anything when enabled and not aimed at r0.
  function automatic logic wr_active(input logic we, input reg_addr_t addr);
    return we && (addr != '0);
  endfunction

  // Guards indexing when the register count is smaller than the index space.
  function automatic logic addr_in_range(input reg_addr_t addr, input int nregs);
    return int'(addr) < nregs;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - decode/writeback-facing bundle of the register file
// master: drives stall, read addresses and both write ports; samples rdata1/rdata2.
// slave : the register file itself.
interface regfile_if #(
  parameter int XLEN = regfile_pkg::CORE_XLEN
);
  import regfile_pkg::*;

  logic            stall;
  reg_addr_t       raddr1;
  reg_addr_t       raddr2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            we1;
  reg_addr_t       waddr1;
  logic [XLEN-1:0] wdata1;
  logic            we2;
  reg_addr_t       waddr2;
  logic [XLEN-1:0] wdata2;

  modport master (
    output stall, raddr1, raddr2,
    output we1, waddr1, wdata1,
    output we2, waddr2, wdata2,
    input  rdata1, rdata2
  );

  modport slave (
    input  stall, raddr1, raddr2,
    input  we1, waddr1, wdata1,
    input  we2, waddr2, wdata2,
    output rdata1, rdata2
  );

endinterface

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - per-read-port write-through bypass mux
// Ports: sel_addr (read index), wr1_en/waddr1/wdata1 and wr2_en/waddr2/wdata2
//        (qualified write ports), arr_data (stored value), rdata (next read data).
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  reg_addr_t       sel_addr,
  input  logic            wr1_en,
  input  reg_addr_t       waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            wr2_en,
  input  reg_addr_t       waddr2,
  input  logic [XLEN-1:0] wdata2,
  input  logic [XLEN-1:0] arr_data,
  output logic [XLEN-1:0] rdata
);

  // Port 1 is checked first so it wins a same-address conflict, matching the array update.
  always_comb begin
    rdata = arr_data;
    if (sel_addr == '0) begin
      rdata = '0;
    end else if (wr1_en && (waddr1 == sel_addr)) begin
      rdata = wdata1;
    end else if (wr2_en && (waddr2 == sel_addr)) begin
      rdata = wdata2;
    end
  end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 2-read/2-write register file with registered, bypassed reads
// Ports: clk, rst (async, active-high), rf (regfile_if.slave: stall, raddr1/2,
//        rdata1/2, we1/waddr1/wdata1, we2/waddr2/wdata2).
module regfile #(
  parameter int NREGS = regfile_pkg::CORE_NREGS,
  parameter int XLEN  = regfile_pkg::CORE_XLEN
) (
  input logic     clk,
  input logic     rst,
  regfile_if.slave rf
);
  import regfile_pkg::*;

  reg_addr_t       ra1_q, ra1_d;
  reg_addr_t       ra2_q, ra2_d;
  logic [XLEN-1:0] rdata1_q, rdata1_d;
  logic [XLEN-1:0] rdata2_q, rdata2_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr1_en, wr2_en;
  logic [XLEN-1:0] arr1, arr2;

  always_comb begin
    // While stalled the captured address is re-used, so rdata keeps refreshing from it.
    ra1_d  = rf.stall ? ra1_q : rf.raddr1;
    ra2_d  = rf.stall ? ra2_q : rf.raddr2;
    wr1_en = wr_active(rf.we1, rf.waddr1) && addr_in_range(rf.waddr1, NREGS);
    wr2_en = wr_active(rf.we2, rf.waddr2) && addr_in_range(rf.waddr2, NREGS);

    regs_d = regs_q;
    if (wr2_en) regs_d[rf.waddr2] = rf.wdata2;
    if (wr1_en) regs_d[rf.waddr1] = rf.wdata1;

    arr1 = addr_in_range(ra1_d, NREGS) ? regs_q[ra1_d] : '0;
    arr2 = addr_in_range(ra2_d, NREGS) ? regs_q[ra2_d] : '0;
  end

  regfile_bypass #(.XLEN(XLEN)) u_bypass1 (
    .sel_addr (ra1_d),
    .wr1_en   (wr1_en),
    .waddr1   (rf.waddr1),
    .wdata1   (rf.wdata1),
    .wr2_en   (wr2_en),
    .waddr2   (rf.waddr2),
    .wdata2   (rf.wdata2),
    .arr_data (arr1),
    .rdata    (rdata1_d)
  );

  regfile_bypass #(.XLEN(XLEN)) u_bypass2 (
    .sel_addr (ra2_d),
    .wr1_en   (wr1_en),
    .waddr1   (rf.waddr1),
    .wdata1   (rf.wdata1),
    .wr2_en   (wr2_en),
    .waddr2   (rf.waddr2),
    .wdata2   (rf.wdata2),
    .arr_data (arr2),
    .rdata    (rdata2_d)
  );

  // Entry 0 is never written from regs_d, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra1_q    <= '0;
      ra2_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      ra1_q    <= ra1_d;
      ra2_q    <= ra2_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      regs_q   <= regs_d;
    end
  end

  assign rf.rdata1 = rdata1_q;
  assign rf.rdata2 = rdata2_q;

endmodule
